// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Parses a byte stream carrying a 16-bit
// little-endian word count followed by little-endian 32-bit instruction words.
// Writes the words into IMEM from word address 0. Holds the core in reset until
// a load finishes cleanly.
// Only DATA_WIDTH = 32 is supported, since a word is assembled from four bytes.
module imem_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 256,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StDone,
        StErr
    } state_e;

    state_e            state_q;
    logic [15:0]       count_q;
    logic [1:0]        byte_q;
    logic [23:0]       word_q;
    logic [ADDR_W-1:0] idx_q;

    logic              accept;
    logic [15:0]       hdr_count;
    logic              last_word;

    // Handshake and header decode; s_ready is a register, so there is no s_valid -> s_ready path.
    always_comb begin
        accept    = s_valid & s_ready;
        hdr_count = {s_data, count_q[7:0]};
        // Compared at 32 bits so a full-depth load is detected even though idx_q rolls over.
        last_word = (32'(idx_q) + 32'd1) == 32'(count_q);
    end

    // Loader FSM; all outputs are registered alongside the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            idx_q      <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state_q    <= StHdr0;
                        busy       <= 1'b1;
                        s_ready    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        core_rst_n <= 1'b0;
                        idx_q      <= '0;
                    end
                end
                StHdr0: begin
                    if (accept) begin
                        count_q[7:0] <= s_data;
                        state_q      <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (accept) begin
                        count_q <= hdr_count;
                        byte_q  <= '0;
                        if (hdr_count == 16'd0) begin
                            state_q    <= StDone;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                            busy       <= 1'b0;
                            s_ready    <= 1'b0;
                        end else if (32'(hdr_count) > MEM_SIZE) begin
                            state_q <= StErr;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            s_ready <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        byte_q <= byte_q + 2'd1;
                        case (byte_q)
                            2'd0: word_q[7:0]   <= s_data;
                            2'd1: word_q[15:8]  <= s_data;
                            2'd2: word_q[23:16] <= s_data;
                            default: begin
                                // Fourth byte completes the word; issue the write next cycle.
                                state_q    <= StWrite;
                                s_ready    <= 1'b0;
                                imem_we    <= 1'b1;
                                imem_addr  <= idx_q;
                                imem_wdata <= DATA_WIDTH'({s_data, word_q});
                            end
                        endcase
                    end
                end
                StWrite: begin
                    idx_q <= idx_q + ADDR_W'(1);
                    if (last_word) begin
                        state_q    <= StDone;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                        busy       <= 1'b0;
                    end else begin
                        state_q <= StData;
                        s_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams, with a
// transaction-level model that derives the expected writes and final status from the stream.
module tb_imem_loader;

    localparam int unsigned MEM_SIZE = 256;
    localparam int unsigned ADDR_W   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(
        .DATA_WIDTH(32),
        .MEM_SIZE  (MEM_SIZE),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic [7:0]  stream [$];
    wr_t         exp_q  [$];
    logic [31:0] wr_log [0:255];
    logic [7:0]  last_addr;
    logic [31:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: write strobes against the model queue, plus per-cycle output rules.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_needs_busy", 32'(s_ready & ~busy), 32'd0);
            chk("core_rst_n_tracks_done", 32'(core_rst_n), 32'(done));
            chk("status_exclusive", 32'((busy & done) | (busy & err) | (done & err)), 32'd0);
            if (imem_we) begin
                chk("no_ready_during_write", 32'(s_ready), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             imem_addr, imem_wdata);
                end else begin
                    chk("write_addr", 32'(imem_addr), 32'(exp_q[0].addr));
                    chk("write_data", imem_wdata, exp_q[0].data);
                    exp_q.delete(0);
                end
                wr_log[imem_addr] = imem_wdata;
                last_addr         = imem_addr;
                last_data         = imem_wdata;
            end
        end
    end

    task automatic check_reset();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    // Model: the header decides the outcome; word i is bytes 2+4i..5+4i, little endian.
    task automatic build_expected(output bit exp_err, output int cnt);
        cnt     = int'({stream[1], stream[0]});
        exp_err = (cnt > int'(MEM_SIZE));
        if (!exp_err) begin
            for (int i = 0; i < cnt; i++) begin
                exp_q.push_back('{addr: 8'(i),
                                  data: {stream[2+4*i+3], stream[2+4*i+2],
                                         stream[2+4*i+1], stream[2+4*i]}});
            end
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_s_ready", 32'(s_ready), 32'd1);
        chk("start_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("start_done_clear", 32'(done), 32'd0);
        chk("start_err_clear", 32'(err), 32'd0);
    endtask

    // Returns at posedge+1 right after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit noise, output bit ok);
        logic rdy;
        for (int i = 0; i < gap; i++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            start   = noise && ($urandom_range(7, 0) == 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        ok      = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            start = noise && ($urandom_range(7, 0) == 0);
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: got s_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic run_load(input int gap_min, input int gap_max, input bit noise,
                            input int stop_after);
        bit exp_err;
        bit ok;
        int cnt;
        int n;
        build_expected(exp_err, cnt);
        do_start();
        n = stream.size();
        for (int i = 0; i < n; i++) begin
            if (i == stop_after) return;
            send_byte(stream[i], int'($urandom_range(gap_max, gap_min)), noise, ok);
            if (!ok) return;
        end
        if (exp_err) begin
            chk("err_flag", 32'(err), 32'd1);
            chk("err_s_ready", 32'(s_ready), 32'd0);
            chk("err_core_rst_n", 32'(core_rst_n), 32'd0);
            chk("err_busy", 32'(busy), 32'd0);
        end else if (cnt == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_core_rst_n", 32'(core_rst_n), 32'd1);
            chk("zero_busy", 32'(busy), 32'd0);
        end else begin
            chk("last_write_strobe", 32'(imem_we), 32'd1);
            chk("last_write_not_done", 32'(done), 32'd0);
            @(posedge clk);
            #1;
            chk("load_done", 32'(done), 32'd1);
            chk("load_core_rst_n", 32'(core_rst_n), 32'd1);
            chk("load_busy", 32'(busy), 32'd0);
            chk("load_err", 32'(err), 32'd0);
        end
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        int kind;
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        #1 check_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset();
        @(posedge clk);
        #1;

        // Two-word program, no stalls.
        stream = {8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
        run_load(0, 0, 1'b0, -1);
        chk("pin_word0", wr_log[0], 32'h00A00513);
        chk("pin_word1", wr_log[1], 32'h00B00593);

        // Same program with 3 idle cycles before every byte.
        wr_log[0] = '0;
        wr_log[1] = '0;
        run_load(3, 3, 1'b0, -1);
        chk("pin_stall_word0", wr_log[0], 32'h00A00513);
        chk("pin_stall_word1", wr_log[1], 32'h00B00593);

        // Oversized count aborts; following bytes are refused; a good load clears err.
        stream = {8'h01, 8'h01};
        run_load(0, 2, 1'b0, -1);
        s_valid = 1'b1;
        s_data  = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 chk("err_refuses_bytes", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        stream = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(0, 2, 1'b0, -1);
        chk("pin_after_err", wr_log[0], 32'hDEADBEEF);

        // Zero count completes with no write.
        stream = {8'h00, 8'h00};
        run_load(0, 1, 1'b0, -1);

        // Reset after two data bytes, then reload from address 0.
        stream = {8'h03, 8'h00};
        for (int i = 0; i < 12; i++) stream.push_back(8'($urandom));
        run_load(0, 1, 1'b0, 4);
        rst = 1'b1;
        #1 check_reset();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        run_load(0, 1, 1'b0, -1);

        // Full-depth load, data = word index, with stray start pulses throughout.
        stream = {8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'(i));
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'h00);
        end
        run_load(0, 0, 1'b1, -1);
        chk("pin_full_last_addr", 32'(last_addr), 32'd255);
        chk("pin_full_last_data", last_data, 32'h000000FF);
        chk("pin_full_mid_data", wr_log[200], 32'd200);

        // Randomized loads.
        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(5, 0));
            if (kind == 0) cnt = 0;
            else if (kind == 1) cnt = int'($urandom_range(300, MEM_SIZE + 1));
            else cnt = int'($urandom_range(12, 1));
            stream = {8'(cnt), 8'(cnt >> 8)};
            if (cnt <= int'(MEM_SIZE)) begin
                for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom));
            end
            run_load(0, 3, 1'($urandom_range(1, 0)), -1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
